// File: rtl/cache_fill_arbiter.sv
// Shared I/D-cache miss controller: arbitrates the two miss requests and
// sequences one block fill from the pipelined main memory into the owning cache.
module cache_fill_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_write_data_array,
    output logic              d_write_data_array,
    output logic              i_write_tag_array,
    output logic              d_write_tag_array,
    output logic              i_busy,
    output logic              d_busy
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state;
    logic              sel_d;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              accept;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // Word offset stays inside the block, so the sum never carries past it.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [CNT_W-1:0]  cnt);
        return b + {{(ADDR_W-OFF_W){1'b0}}, cnt, 1'b0};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            sel_d             <= 1'b0;
            base              <= '0;
            issue_cnt         <= '0;
            recv_cnt          <= '0;
            mem_enable        <= 1'b0;
            i_write_tag_array <= 1'b0;
            d_write_tag_array <= 1'b0;
            i_busy            <= 1'b0;
            d_busy            <= 1'b0;
        end else begin
            i_write_tag_array <= 1'b0;
            d_write_tag_array <= 1'b0;
            case (state)
                IDLE: begin
                    // D-cache wins a tie: its miss belongs to the older instruction.
                    if (icache_miss || dcache_miss) begin
                        sel_d      <= dcache_miss;
                        base       <= dcache_miss ? block_base(dcache_miss_addr)
                                                  : block_base(icache_miss_addr);
                        issue_cnt  <= '0;
                        recv_cnt   <= '0;
                        mem_enable <= 1'b1;
                        i_busy     <= !dcache_miss;
                        d_busy     <= dcache_miss;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (mem_enable) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        if (issue_cnt == LAST_WORD) mem_enable <= 1'b0;
                    end
                    if (mem_data_valid) begin
                        recv_cnt <= recv_cnt + CNT_W'(1);
                        if (recv_cnt == LAST_WORD) begin
                            mem_enable        <= 1'b0;
                            i_write_tag_array <= !sel_d;
                            d_write_tag_array <= sel_d;
                            state             <= DONE;
                        end
                    end
                end
                DONE: begin
                    i_busy <= 1'b0;
                    d_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Returning words are written the same cycle they arrive; stray valids outside FILL are dropped.
    assign accept             = (state == FILL) && mem_data_valid;
    assign mem_addr           = word_addr(base, issue_cnt);
    assign fill_addr          = word_addr(base, recv_cnt);
    assign fill_data          = accept ? mem_data_in : '0;
    assign i_write_data_array = accept && !sel_d;
    assign d_write_data_array = accept && sel_d;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter with a fixed-latency memory model
// that can hold its valid low for a window of cycles.
module tb_cache_fill_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss, dcache_miss;
    logic [15:0] icache_miss_addr, dcache_miss_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        mem_enable;
    logic [15:0] mem_addr, fill_addr, fill_data;
    logic        i_write_data_array, d_write_data_array;
    logic        i_write_tag_array, d_write_tag_array;
    logic        i_busy, d_busy;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
        .mem_enable(mem_enable), .mem_addr(mem_addr),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .i_write_data_array(i_write_data_array), .d_write_data_array(d_write_data_array),
        .i_write_tag_array(i_write_tag_array), .d_write_tag_array(d_write_tag_array),
        .i_busy(i_busy), .d_busy(d_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    typedef struct packed {logic [15:0] addr; logic d;} wr_t;
    typedef struct packed {logic [15:0] addr; int ready;} req_t;

    logic [15:0] exp_iss[$];
    wr_t         exp_wr[$];
    logic        exp_tag[$];
    req_t        mem_q[$];
    int          iss_cyc[$], wr_cyc[$], tag_cyc[$];
    int          stall_lo = -1, stall_hi = -1;

    task automatic expect_fill(input logic [15:0] miss_addr, input logic d);
        logic [15:0] b;
        b = {miss_addr[15:4], 4'h0};
        for (int i = 0; i < 8; i++) begin
            exp_iss.push_back(b + 16'(2 * i));
            exp_wr.push_back('{addr: b + 16'(2 * i), d: d});
        end
        exp_tag.push_back(d);
    endtask

    task automatic clear_logs();
        iss_cyc.delete();
        wr_cyc.delete();
        tag_cyc.delete();
    endtask

    task automatic wait_tags(input int n, input int budget);
        int t;
        t = 0;
        while (tag_cyc.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("tag_wait", 32'(tag_cyc.size() >= n), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Memory model: one read per issue, returned L cycles later unless stalled.
    initial begin
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_q.size() > 0 && mem_q[0].ready <= cyc &&
                !(cyc >= stall_lo && cyc <= stall_hi)) begin
                mem_data_valid = 1'b1;
                mem_data_in    = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                mem_data_valid = 1'b0;
                mem_data_in    = 16'hDEAD;
            end
        end
    end

    wr_t  mon_e;
    logic mon_t;

    // Monitor: compares every issue, write and tag pulse against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_enable) begin
                mem_q.push_back('{addr: mem_addr, ready: cyc + L});
                iss_cyc.push_back(cyc);
                if (exp_iss.size() == 0) check("iss_unexpected", 32'd1, 32'd0);
                else check("mem_addr", 32'(mem_addr), 32'(exp_iss.pop_front()));
            end
            if (i_write_data_array || d_write_data_array) begin
                wr_cyc.push_back(cyc);
                if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = exp_wr.pop_front();
                    check("fill_addr", 32'(fill_addr), 32'(mon_e.addr));
                    check("fill_data", 32'(fill_data), 32'(mem_word(mon_e.addr)));
                    check("wr_owner", 32'({i_write_data_array, d_write_data_array}),
                          32'({!mon_e.d, mon_e.d}));
                    check("busy_wr", 32'({i_busy, d_busy}), 32'({!mon_e.d, mon_e.d}));
                end
            end
            if (i_write_tag_array || d_write_tag_array) begin
                tag_cyc.push_back(cyc);
                if (exp_tag.size() == 0) check("tag_unexpected", 32'd1, 32'd0);
                else begin
                    mon_t = exp_tag.pop_front();
                    check("tag_owner", 32'({i_write_tag_array, d_write_tag_array}),
                          32'({!mon_t, mon_t}));
                    check("busy_tag", 32'({i_busy, d_busy}), 32'({!mon_t, mon_t}));
                end
                if (d_write_tag_array) dcache_miss = 1'b0;
                if (i_write_tag_array) icache_miss = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int k;
    int n0;

    initial begin
        rst = 1'b1;
        icache_miss = 1'b0; icache_miss_addr = 16'h0;
        dcache_miss = 1'b0; dcache_miss_addr = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_busy", 32'({i_busy, d_busy}), 32'd0);
        check("rst_tags", 32'({i_write_tag_array, d_write_tag_array}), 32'd0);
        check("rst_addrs", {mem_addr, fill_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Lone D miss with latency checks
        clear_logs();
        k = cyc;
        dcache_miss_addr = 16'h1234; dcache_miss = 1'b1;
        expect_fill(16'h1234, 1'b1);
        wait_tags(1, 60);
        check("t1_iss_count", 32'(iss_cyc.size()), 32'd8);
        check("t1_iss_first", 32'(iss_cyc[0]), 32'(k + 1));
        check("t1_iss_last", 32'(iss_cyc[7]), 32'(k + 8));
        check("t1_wr_count", 32'(wr_cyc.size()), 32'd8);
        check("t1_wr_first", 32'(wr_cyc[0]), 32'(k + 5));
        check("t1_wr_last", 32'(wr_cyc[7]), 32'(k + 12));
        check("t1_tag", 32'(tag_cyc[0]), 32'(k + 13));
        check("t1_idle_busy", 32'({i_busy, d_busy, mem_enable}), 32'd0);

        // Simultaneous misses: D first, I starts two cycles after D's tag pulse
        clear_logs();
        icache_miss_addr = 16'h0040; icache_miss = 1'b1;
        dcache_miss_addr = 16'h2008; dcache_miss = 1'b1;
        expect_fill(16'h2008, 1'b1);
        expect_fill(16'h0040, 1'b0);
        wait_tags(2, 120);
        check("t2_iss_count", 32'(iss_cyc.size()), 32'd16);
        check("t2_i_start", 32'(iss_cyc[8]), 32'(tag_cyc[0] + 2));

        // Memory valid held low for three cycles mid-stream
        clear_logs();
        k = cyc;
        stall_lo = k + 7; stall_hi = k + 9;
        dcache_miss_addr = 16'h5678; dcache_miss = 1'b1;
        expect_fill(16'h5678, 1'b1);
        wait_tags(1, 80);
        stall_lo = -1; stall_hi = -1;
        check("t3_wr_count", 32'(wr_cyc.size()), 32'd8);
        check("t3_wr_resume", 32'(wr_cyc[2]), 32'(k + 10));
        check("t3_wr_last", 32'(wr_cyc[7]), 32'(k + 15));
        check("t3_tag_after", 32'(tag_cyc[0]), 32'(wr_cyc[7] + 1));

        // Asynchronous reset in the fourth FILL cycle
        clear_logs();
        k = cyc;
        dcache_miss_addr = 16'h3000; dcache_miss = 1'b1;
        expect_fill(16'h3000, 1'b1);
        while (cyc < k + 4) @(negedge clk);
        #2;
        rst = 1'b1;
        dcache_miss = 1'b0;
        #1;
        check("t4_rst_mem_enable", 32'(mem_enable), 32'd0);
        check("t4_rst_busy", 32'({i_busy, d_busy}), 32'd0);
        check("t4_rst_addr", 32'(mem_addr), 32'd0);
        exp_iss.delete(); exp_wr.delete(); exp_tag.delete();
        @(negedge clk);
        rst = 1'b0;
        n0 = wr_cyc.size();
        repeat (8) @(negedge clk);
        check("t4_trailing_wr", 32'(wr_cyc.size() - n0), 32'd0);
        check("t4_mem_drained", 32'(mem_q.size()), 32'd0);
        clear_logs();
        dcache_miss_addr = 16'h3000; dcache_miss = 1'b1;
        expect_fill(16'h3000, 1'b1);
        wait_tags(1, 60);
        check("t4_refill_wr", 32'(wr_cyc.size()), 32'd8);

        // Top-of-memory block; request dropped in the third FILL cycle
        clear_logs();
        k = cyc;
        icache_miss_addr = 16'hFFFA; icache_miss = 1'b1;
        expect_fill(16'hFFFA, 1'b0);
        while (cyc < k + 3) @(negedge clk);
        icache_miss = 1'b0;
        wait_tags(1, 60);
        check("t5_wr_count", 32'(wr_cyc.size()), 32'd8);
        check("t5_tag_count", 32'(tag_cyc.size()), 32'd1);

        repeat (4) @(negedge clk);
        check("end_exp_iss", 32'(exp_iss.size()), 32'd0);
        check("end_exp_wr", 32'(exp_wr.size()), 32'd0);
        check("end_exp_tag", 32'(exp_tag.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
